// File: rtl/sync_trig_pulse_array.sv
// N-channel trigger pulse generator: delayed, width-programmable pulses per channel,
// with optional feedback timeout check and stretched status LEDs (SYNCTRIG_FB_CHECK_EN).
module sync_trig_pulse_array #(
    parameter int unsigned CH_NUM   = 8,
    parameter int unsigned DLY_W    = 32,
    parameter int unsigned PW_W     = 24,
    parameter int unsigned FBTO_W   = 16,
    parameter int unsigned LED_HOLD = 1000000
) (
    input  logic                     io_clk,
    input  logic                     io_rst,
    input  logic                     io_trig,
    input  logic [CH_NUM-1:0]        io_ch_en,
    input  logic [CH_NUM*DLY_W-1:0]  io_dly,
    input  logic [CH_NUM*PW_W-1:0]   io_pw,
    input  logic [FBTO_W-1:0]        io_fb_to,
    input  logic [CH_NUM-1:0]        io_fb,
    input  logic                     io_clr,
    output logic [CH_NUM-1:0]        io_pulse,
    output logic [CH_NUM-1:0]        io_led,
    output logic [CH_NUM-1:0]        io_busy,
    output logic [CH_NUM-1:0]        io_fb_err,
    output logic [CH_NUM-1:0]        io_ovr,
    output logic                     io_any_err
);

    localparam int unsigned LED_W = $clog2(LED_HOLD + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_PULSE,
        ST_WAIT_FB
    } state_t;

    logic              trig_d;
    logic              start;
    logic [CH_NUM-1:0] fb_err_nxt;
    logic [CH_NUM-1:0] ovr_nxt;
    logic              any_err_q;

    // Rising-edge detect on the already-synchronous trigger level.
    always_ff @(posedge io_clk) begin
        if (io_rst) begin
            trig_d <= 1'b0;
        end else begin
            trig_d <= io_trig;
        end
    end

    assign start = io_trig & ~trig_d;

`ifndef SYNCTRIG_FB_CHECK_EN
    logic unused_fb;
    assign unused_fb = ^{io_fb, io_fb_to};
`endif

    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
        state_t             state_q, state_nxt;
        logic [DLY_W-1:0]   dly_q, dly_nxt;
        logic [PW_W-1:0]    pw_q, pw_nxt;
        logic [LED_W-1:0]   led_cnt_q, led_cnt_nxt;
        logic               pulse_q, busy_q, led_q, fb_err_q, ovr_q;
        logic               ok, tmo, led_load, ovr_set;
`ifdef SYNCTRIG_FB_CHECK_EN
        logic [FBTO_W-1:0]  to_q, to_nxt;
        logic               fb_seen_q, fb_seen_nxt;
`endif

        // Channel sequencer: D and P are latched at launch so later config writes are ignored.
        always_comb begin
            state_nxt   = state_q;
            dly_nxt     = dly_q;
            pw_nxt      = pw_q;
`ifdef SYNCTRIG_FB_CHECK_EN
            to_nxt      = to_q;
            fb_seen_nxt = fb_seen_q;
`endif
            ok          = 1'b0;
            tmo         = 1'b0;
            led_load    = 1'b0;
            ovr_set     = start & io_ch_en[gi] & (state_q != ST_IDLE);

            case (state_q)
                ST_IDLE: begin
                    if (start && io_ch_en[gi]) begin
                        dly_nxt     = io_dly[gi*DLY_W +: DLY_W];
                        pw_nxt      = io_pw[gi*PW_W +: PW_W];
`ifdef SYNCTRIG_FB_CHECK_EN
                        to_nxt      = '0;
                        fb_seen_nxt = 1'b0;
`endif
                        state_nxt   = ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    if (dly_q == '0) begin
                        state_nxt = (pw_q == '0) ? ST_IDLE : ST_PULSE;
                    end else begin
                        dly_nxt = dly_q - DLY_W'(1);
                    end
                end
                ST_PULSE: begin
`ifdef SYNCTRIG_FB_CHECK_EN
                    fb_seen_nxt = fb_seen_q | io_fb[gi];
`endif
                    if (pw_q == PW_W'(1)) begin
`ifdef SYNCTRIG_FB_CHECK_EN
                        state_nxt = ST_WAIT_FB;
`else
                        state_nxt = ST_IDLE;
                        led_load  = 1'b1;
`endif
                    end else begin
                        pw_nxt = pw_q - PW_W'(1);
                    end
                end
                ST_WAIT_FB: begin
`ifdef SYNCTRIG_FB_CHECK_EN
                    // Window of T+1 decisions; feedback on the last one still counts.
                    if (io_fb[gi] || fb_seen_q) begin
                        ok        = 1'b1;
                        led_load  = 1'b1;
                        state_nxt = ST_IDLE;
                    end else if (to_q == io_fb_to) begin
                        tmo       = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        to_nxt = to_q + FBTO_W'(1);
                    end
`else
                    state_nxt = ST_IDLE;
`endif
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase

            if (led_load) begin
                led_cnt_nxt = LED_W'(LED_HOLD);
            end else if (led_cnt_q != '0) begin
                led_cnt_nxt = led_cnt_q - LED_W'(1);
            end else begin
                led_cnt_nxt = '0;
            end
        end

        // Sticky flags: a set in the same cycle as a clear wins.
        assign fb_err_nxt[gi] = tmo | (fb_err_q & ~io_clr);
        assign ovr_nxt[gi]    = ovr_set | (ovr_q & ~io_clr);

        always_ff @(posedge io_clk) begin
            if (io_rst) begin
                state_q   <= ST_IDLE;
                dly_q     <= '0;
                pw_q      <= '0;
                led_cnt_q <= '0;
                pulse_q   <= 1'b0;
                busy_q    <= 1'b0;
                led_q     <= 1'b0;
                fb_err_q  <= 1'b0;
                ovr_q     <= 1'b0;
`ifdef SYNCTRIG_FB_CHECK_EN
                to_q      <= '0;
                fb_seen_q <= 1'b0;
`endif
            end else begin
                state_q   <= state_nxt;
                dly_q     <= dly_nxt;
                pw_q      <= pw_nxt;
                led_cnt_q <= led_cnt_nxt;
                pulse_q   <= (state_nxt == ST_PULSE);
                // Busy lags the state by one cycle, except it drops together with the verdict flag.
                busy_q    <= (state_q != ST_IDLE) & ~ok & ~tmo;
                led_q     <= (led_cnt_nxt != '0);
                fb_err_q  <= fb_err_nxt[gi];
                ovr_q     <= ovr_nxt[gi];
`ifdef SYNCTRIG_FB_CHECK_EN
                to_q      <= to_nxt;
                fb_seen_q <= fb_seen_nxt;
`endif
            end
        end

        assign io_pulse[gi]  = pulse_q;
        assign io_busy[gi]   = busy_q;
        assign io_led[gi]    = led_q;
        assign io_fb_err[gi] = fb_err_q;
        assign io_ovr[gi]    = ovr_q;
    end

    always_ff @(posedge io_clk) begin
        if (io_rst) begin
            any_err_q <= 1'b0;
        end else begin
            any_err_q <= |(fb_err_nxt | ovr_nxt);
        end
    end

    assign io_any_err = any_err_q;

endmodule

// File: tb/tb_sync_trig_pulse_array.sv
// Bench for sync_trig_pulse_array: directed scenarios plus random traffic against a
// timestamp-based reference model of each channel's launch schedule.
module tb_sync_trig_pulse_array;

    localparam int unsigned CH   = 8;
    localparam int unsigned DW   = 8;
    localparam int unsigned PWW  = 6;
    localparam int unsigned TW   = 4;
    localparam int unsigned HOLD = 10;
`ifdef SYNCTRIG_FB_CHECK_EN
    localparam bit FBCHK = 1'b1;
`else
    localparam bit FBCHK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst, trig, clr;
    logic [CH-1:0]     en, fb;
    logic [CH*DW-1:0]  dly;
    logic [CH*PWW-1:0] pw;
    logic [TW-1:0]     fb_to;
    logic [CH-1:0]     pulse, led, busy, fb_err, ovr;
    logic              any_err;

    always #5 clk = ~clk;

    sync_trig_pulse_array #(
        .CH_NUM(CH), .DLY_W(DW), .PW_W(PWW), .FBTO_W(TW), .LED_HOLD(HOLD)
    ) dut (
        .io_clk(clk), .io_rst(rst), .io_trig(trig), .io_ch_en(en),
        .io_dly(dly), .io_pw(pw), .io_fb_to(fb_to), .io_fb(fb), .io_clr(clr),
        .io_pulse(pulse), .io_led(led), .io_busy(busy), .io_fb_err(fb_err),
        .io_ovr(ovr), .io_any_err(any_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Reference model: each launch is a record of absolute edge times derived from D, P, T.
    int  t_now = 0;
    bit  rec[CH], act[CH], eknown[CH], fbs[CH], merr[CH], movr[CH];
    int  lk[CH], ld[CH], lp[CH], le[CH], led_last[CH];
    bit  trig_prev = 1'b0;
    bit  model_ok  = 1'b0;
    logic [CH-1:0] e_pulse, e_busy, e_led, e_err, e_ovr;
    logic          e_any;

    always @(posedge clk) begin : ref_model
        bit st, busy_t, eset, oset;
        int wbeg;
        t_now++;
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                rec[i] = 0; act[i] = 0; eknown[i] = 0; fbs[i] = 0;
                merr[i] = 0; movr[i] = 0; led_last[i] = -1;
            end
            trig_prev = 1'b0;
        end else begin
            st = trig && !trig_prev;
            trig_prev = trig;
            for (int i = 0; i < CH; i++) begin
                eset = 0;
                oset = 0;
                if (act[i] && eknown[i] && t_now > le[i]) act[i] = 0;
                busy_t = act[i];
                if (act[i] && lp[i] > 0) begin
                    if (FBCHK) begin
                        if (!eknown[i]) begin
                            wbeg = lk[i] + 2 + ld[i] + lp[i];
                            if (t_now >= lk[i] + 2 + ld[i] && t_now < wbeg && fb[i]) fbs[i] = 1;
                            if (t_now >= wbeg) begin
                                if (fb[i] || fbs[i]) begin
                                    le[i] = t_now; eknown[i] = 1;
                                    led_last[i] = t_now + HOLD - 1;
                                end else if (t_now - wbeg == int'(fb_to)) begin
                                    le[i] = t_now; eknown[i] = 1; eset = 1;
                                end
                            end
                        end
                    end else if (t_now == le[i]) begin
                        led_last[i] = t_now + HOLD - 1;
                    end
                end
                if (st && en[i]) begin
                    if (busy_t) begin
                        oset = 1;
                    end else begin
                        rec[i] = 1; act[i] = 1; lk[i] = t_now; fbs[i] = 0;
                        ld[i] = int'(dly[i*DW +: DW]);
                        lp[i] = int'(pw[i*PWW +: PWW]);
                        if (lp[i] == 0) begin
                            le[i] = lk[i] + 1 + ld[i]; eknown[i] = 1;
                        end else if (!FBCHK) begin
                            le[i] = lk[i] + 1 + ld[i] + lp[i]; eknown[i] = 1;
                        end else begin
                            eknown[i] = 0;
                        end
                    end
                end
                merr[i] = eset || (merr[i] && !clr);
                movr[i] = oset || (movr[i] && !clr);
            end
        end
        for (int i = 0; i < CH; i++) begin
            e_pulse[i] = rec[i] && lp[i] > 0 && t_now >= lk[i] + 1 + ld[i] && t_now <= lk[i] + ld[i] + lp[i];
            e_busy[i]  = rec[i] && t_now >= lk[i] + 1 &&
                         (!eknown[i] || ((FBCHK && lp[i] > 0) ? (t_now < le[i]) : (t_now <= le[i])));
            e_led[i]   = led_last[i] >= t_now;
            e_err[i]   = merr[i];
            e_ovr[i]   = movr[i];
        end
        e_any = |(e_err | e_ovr);
        model_ok = 1'b1;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check_eq("pulse", 32'(pulse), 32'(e_pulse));
            check_eq("busy", 32'(busy), 32'(e_busy));
            check_eq("led", 32'(led), 32'(e_led));
            check_eq("fb_err", 32'(fb_err), 32'(e_err));
            check_eq("ovr", 32'(ovr), 32'(e_ovr));
            check_eq("any_err", 32'(any_err), 32'(e_any));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ch(input int c, input int d, input int p);
        dly[c*DW +: DW]   = DW'(d);
        pw[c*PWW +: PWW]  = PWW'(p);
    endtask

    // Raise trigger for one sampling edge; returns in the cycle after that edge.
    task automatic pulse_trig();
        trig = 1'b1;
        cycles(1);
        trig = 1'b0;
    endtask

    initial begin
        rst = 1'b1; trig = 1'b0; clr = 1'b0; en = '0; fb = '0;
        dly = '0; pw = '0; fb_to = TW'(4);
        cycles(3);
        check_eq("rst_pulse", 32'(pulse), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_led", 32'(led), 32'h0);
        check_eq("rst_any_err", 32'(any_err), 32'h0);
        rst = 1'b0;

        // Basic launch, zero delay / zero width channels
        en = '1;
        set_ch(0, 5, 3); set_ch(1, 0, 1); set_ch(2, 3, 0); set_ch(3, 1, 2);
        for (int c = 4; c < CH; c++) set_ch(c, c - 2, 1);
        pulse_trig();
        cycles(30);
        clr = 1'b1; cycles(1); clr = 1'b0;

        // Feedback on the 5th window cycle of ch3 (T=4)
        en = 8'h08; set_ch(3, 1, 2);
        pulse_trig();
        cycles(8); fb[3] = 1'b1; cycles(1); fb[3] = 1'b0;
        cycles(20);

        // No feedback -> timeout, then clear
        pulse_trig();
        cycles(20);
        clr = 1'b1; cycles(1); clr = 1'b0;
        cycles(2);

        // Retrigger during DELAY with a coincident clear
        en = 8'h01; set_ch(0, 5, 3);
        pulse_trig();
        cycles(1);
        trig = 1'b1; clr = 1'b1;
        cycles(1);
        trig = 1'b0; clr = 1'b0;
        cycles(25);

        // Enable mask, config changes while running
        en = 8'h05; set_ch(0, 2, 6); set_ch(2, 1, 3);
        pulse_trig();
        cycles(4);
        en[0] = 1'b0; set_ch(0, 9, 1); set_ch(2, 0, 0);
        cycles(20);

        // Reset mid-pulse with trigger held through release
        en = 8'h0F; set_ch(0, 1, 8); set_ch(1, 2, 2); set_ch(2, 0, 3); set_ch(3, 3, 1);
        pulse_trig();
        cycles(4);
        rst = 1'b1; trig = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(1);
        trig = 1'b0;
        cycles(25);

        // Maximum delay for the configured counter width
        en = 8'h10; set_ch(4, (1 << DW) - 1, 1);
        pulse_trig();
        cycles((1 << DW) + 20);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            trig = ($urandom_range(0, 3) == 0);
            en   = CH'($urandom);
            fb   = CH'($urandom) & CH'($urandom) & CH'($urandom);
            for (int c = 0; c < CH; c++) set_ch(c, int'($urandom_range(0, 6)), int'($urandom_range(0, 4)));
            clr  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 299) == 0) begin
                rst   = 1'b1;
                fb_to = TW'($urandom_range(0, 5));
            end else begin
                rst = 1'b0;
            end
            cycles(1);
        end
        rst = 1'b0; trig = 1'b0; clr = 1'b0; fb = '0;
        cycles(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_trig_pulse_array.md
# sync_trig_pulse_array

Parametrised N-channel synchronous trigger pulse generator, the next generation of the fixed 8-channel sync-trigger logic. On a trigger edge it launches, per enabled channel, a delayed pulse of programmable width. It then optionally checks a per-channel feedback input within a timeout and drives a stretched status LED. It sits in the 10 MHz logic domain between the trigger-drive input, the register file that supplies its configuration vectors, and the pulse, LED and feedback pins.

## Interface
- CH_NUM, 8, number of channels (1..32)
- DLY_W, 32, delay counter width
- PW_W, 24, pulse-width counter width
- FBTO_W, 16, feedback-timeout counter width
- LED_HOLD, 1000000, LED stretch length in clocks (≥1)

Ports:
- io_clk  in  1  logic clock
- io_rst  in  1  reset; one clock, reset is synchronous and active-high
- io_trig  in  1  trigger level, already synchronous to io_clk
- io_ch_en  in  CH_NUM  per-channel enable
- io_dly  in  CH_NUM*DLY_W  per-channel delay D, channel i at [i*DLY_W +: DLY_W]
- io_pw  in  CH_NUM*PW_W  per-channel pulse width P
- io_fb_to  in  FBTO_W  shared feedback timeout T
- io_fb  in  CH_NUM  feedback inputs, active-high, synchronous
- io_clr  in  1  clears sticky flags
- io_pulse  out  CH_NUM  pulse outputs
- io_led  out  CH_NUM  stretched status LEDs
- io_busy  out  CH_NUM  channel not IDLE
- io_fb_err  out  CH_NUM  sticky feedback-timeout flag
- io_ovr  out  CH_NUM  sticky retrigger-while-busy flag
- io_any_err  out  1  OR of io_fb_err and io_ovr

## Operation
- **Trigger edge detect:** one register trig_d. start = io_trig & ~trig_d.
- **Launch:** on start, each channel with io_ch_en[i]=1 in IDLE latches D and P, then enters DELAY.
  - Disabled channels ignore start.
  - A channel not in IDLE ignores start and sets io_ovr[i].
- **Per-channel FSM:** IDLE → DELAY → PULSE → WAIT_FB → IDLE.
  - **DELAY:** counts D cycles. With D=0 it leaves after 1 cycle.
  - **PULSE:** io_pulse[i]=1 for exactly P cycles. With P=0 the channel returns to IDLE from DELAY: no pulse, no feedback check, no LED.
  - **WAIT_FB:** fb_seen is set if io_fb[i] was high during any PULSE cycle.
    - Each cycle with io_fb[i] or fb_seen set, the channel reports OK and returns to IDLE.
    - Otherwise, when cnt==T, it sets io_fb_err[i] and returns to IDLE.
    - Otherwise cnt increments.
    - The window is T+1 cycles. Feedback on the final cycle counts as OK.
- **LED:** on OK, a per-channel counter loads LED_HOLD and io_led[i]=1 while the counter is nonzero. A new OK reloads the counter.
- **Config stability:** changing io_dly, io_pw or io_ch_en mid-operation does not affect a running channel. io_fb_to is read live.
- **Sticky flags:** io_clr clears io_fb_err and io_ovr. If a set and io_clr occur in the same cycle, the set wins.
- **Reset:** io_rst mid-operation aborts all channels. Every output reads 0 the cycle after the reset edge, and trig_d=0. A trigger held high through reset release therefore produces a start.

## Timing
- Reset values: io_pulse, io_led, io_busy, io_fb_err, io_ovr, io_any_err are all 0.
- Reference point: the trigger edge sampled at clock edge k (io_trig=1 at k, 0 at k-1).
- io_busy[i] rises after edge k+1.
- io_pulse[i] rises after edge k+1+D and is high for P cycles, falling after edge k+1+D+P.
- WAIT_FB occupies cycles from k+1+D+P.
- io_led[i] rises the cycle after the OK decision.
- io_fb_err[i] rises the cycle after the timeout decision.
- io_busy[i] falls in the same cycle as the flag update.
- Earliest accepted retrigger: the cycle after io_busy[i] falls.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Counter widths:
  - The D counter is DLY_W bits, with no wrap: the maximum D is 2^DLY_W-1.
  - The P counter is PW_W bits.
  - The T counter is FBTO_W bits.
  - The LED counter is clog2(LED_HOLD+1) bits.

## Configuration
- Macro: SYNCTRIG_FB_CHECK_EN.
- **Defined:** the feedback check and LED behaviour are exactly as above.
- **Undefined:**
  - WAIT_FB is removed and PULSE returns directly to IDLE.
  - The LED is loaded at the pulse falling edge.
  - io_fb_err is tied 0, and io_fb and io_fb_to are unused.

## Test plan
- **Basic launch:** CH_NUM=8, all channels enabled, ch0 D=5 P=3, single trigger edge at edge k → io_pulse[0] high for cycles k+6..k+8, io_busy[0] rises after k+1.
- **Zero delay/width:** ch1 D=0 P=1 → 1-cycle pulse after edge k+1. ch2 P=0 → no pulse, no LED, io_busy[2] high for D+1 cycles only.
- **Feedback (macro defined), T=4:**
  - io_fb[3] asserted on the 5th WAIT_FB cycle → OK, io_led[3] high for LED_HOLD cycles (use LED_HOLD=10).
  - No io_fb → io_fb_err[3]=1, io_any_err=1.
  - io_clr → flags return to 0.
- **Retrigger:** second trigger edge while ch0 is in DELAY → ch0 pulse timing unchanged, io_ovr[0]=1. io_clr in the same cycle as the overrun → io_ovr stays 1.
- **Enable mask:** io_ch_en=8'b0000_0101 → only io_pulse[0] and io_pulse[2] toggle. Clearing io_ch_en[0] during PULSE does not shorten the pulse.
- **Reset mid-pulse:** io_rst during PULSE → all outputs 0 next cycle. Trigger held high at reset release → new launch with the latched configuration.
